// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the line/frame total helper.
package vga_timing_pkg;

    localparam int unsigned DEF_CLK_DIV = 4;

    localparam int unsigned DEF_H_VIS  = 640;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;

    localparam int unsigned DEF_V_VIS  = 480;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;

    localparam int unsigned DEF_CW  = 10;
    localparam int unsigned DEF_FCW = 8;

    // Total period of one axis: visible + front porch + sync + back porch.
    function automatic int unsigned calc_total(
        input int unsigned vis,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the generator to the graphics unit and frame-paced logic.
interface vga_timing_gen_if #(
    parameter int unsigned CW  = 10,
    parameter int unsigned FCW = 8
) ();

    logic           pix_tick;
    logic           h_sync;
    logic           v_sync;
    logic           video_on;
    logic [CW-1:0]  pix_x;
    logic [CW-1:0]  pix_y;
    logic           line_start;
    logic           frame_start;
    logic [FCW-1:0] frame_count;

    modport master (
        output pix_tick, h_sync, v_sync, video_on, pix_x, pix_y,
               line_start, frame_start, frame_count
    );

    modport slave (
        input  pix_tick, h_sync, v_sync, video_on, pix_x, pix_y,
               line_start, frame_start, frame_count
    );

endinterface

// File: rtl/vga_timing_gen_pix_tick_div.sv
// System-clock divider producing a one-cycle pixel-enable strobe.
module pix_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic pix_tick
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;

    // Divider counts 0..CLK_DIV-1 only while running; frozen otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else if (enable) begin
            if (div_q == DIV_MAX) div_q <= '0;
            else                  div_q <= div_q + DW'(1);
        end
    end

    // Strobe is decoded from the registered count; suppressed during reset.
    assign pix_tick = enable && !reset && (div_q == DIV_MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel tick, position, syncs, strobes, frame count.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_VIS    = DEF_H_VIS,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_VIS    = DEF_V_VIS,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CW       = DEF_CW,
    parameter int unsigned FCW      = DEF_FCW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = calc_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calc_total(V_VIS, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS_C = CW'(H_VIS);
    localparam logic [CW-1:0] V_VIS_C = CW'(V_VIS);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_VIS + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_VIS + V_FP + V_SYNC);

    logic           tick;
    logic           line_start_c;
    logic           frame_start_c;
    logic [CW-1:0]  x_q, y_q, x_d, y_d;
    logic [FCW-1:0] fc_q;
    logic           video_on_q, h_sync_q, v_sync_q;

    pix_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .pix_tick (tick)
    );

    // Next position and end-of-line/frame strobes from the registered position.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        line_start_c  = tick && (x_q == H_LAST);
        frame_start_c = line_start_c && (y_q == V_LAST);
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    // Position, frame count and area/sync flags; flags use next position so they align with pix_x/pix_y.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q        <= '0;
            y_q        <= '0;
            fc_q       <= '0;
            video_on_q <= 1'b0;
            h_sync_q   <= ~SYNC_POL;
            v_sync_q   <= ~SYNC_POL;
        end else if (enable) begin
            x_q        <= x_d;
            y_q        <= y_d;
            if (frame_start_c) fc_q <= fc_q + FCW'(1);
            video_on_q <= (x_d < H_VIS_C) && (y_d < V_VIS_C);
            h_sync_q   <= ((x_d >= HS_BEG) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
            v_sync_q   <= ((y_d >= VS_BEG) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign vga.pix_tick    = tick;
    assign vga.line_start  = line_start_c;
    assign vga.frame_start = frame_start_c;
    assign vga.pix_x       = x_q;
    assign vga.pix_y       = y_q;
    assign vga.video_on    = video_on_q;
    assign vga.h_sync      = h_sync_q;
    assign vga.v_sync      = v_sync_q;
    assign vga.frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing (u_a) and a tiny 8x6 configuration (u_b).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, en_a, rst_b, en_b;

    vga_timing_gen_if #(.CW(10), .FCW(8)) va ();
    vga_timing_gen_if #(.CW(4),  .FCW(2)) vb ();

    vga_timing_gen u_a (
        .clk    (clk),
        .reset  (rst_a),
        .enable (en_a),
        .vga    (va.master)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CW(4), .FCW(2)
    ) u_b (
        .clk    (clk),
        .reset  (rst_b),
        .enable (en_b),
        .vga    (vb.master)
    );

    int errors = 0;
    int checks = 0;

    // Count one comparison and report it if observed differs from expected.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ticks, hs_lo, vid_lo, vs_bad, first_hs, first_tick, ls1, ls2, frozen_bad;
        int snap_x, snap_y, snap_hs, snap_vs, snap_vid, snap_fc;
        int vb_vs_hi, vb_vid_hi, fs_k;
        bit found;

        rst_a = 1'b1; en_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b1;
        repeat (3) step();

        // Reset state.
        check("rst_x",    32'(va.pix_x), 0);
        check("rst_y",    32'(va.pix_y), 0);
        check("rst_vid",  32'(va.video_on), 0);
        check("rst_hs",   32'(va.h_sync), 1);
        check("rst_vs",   32'(va.v_sync), 1);
        check("rst_fc",   32'(va.frame_count), 0);
        check("rst_tick", 32'(va.pix_tick), 0);
        check("rst_ls",   32'(va.line_start), 0);
        check("rst_b_hs", 32'(vb.h_sync), 0);
        check("rst_b_vs", 32'(vb.v_sync), 0);

        // First clock after release.
        rst_a = 1'b0;
        step();
        check("rel_x",   32'(va.pix_x), 0);
        check("rel_y",   32'(va.pix_y), 0);
        check("rel_vid", 32'(va.video_on), 1);
        check("rel_hs",  32'(va.h_sync), 1);
        check("rel_vs",  32'(va.v_sync), 1);
        check("rel_fc",  32'(va.frame_count), 0);

        // One full line at default timing, n = clocks since release.
        ticks = 0; hs_lo = 0; vid_lo = 0; vs_bad = 0;
        first_hs = -1; first_tick = -1; ls1 = -1;
        for (int n = 2; n <= 3200; n++) begin
            step();
            if (va.pix_tick) begin
                ticks++;
                if (first_tick < 0) first_tick = n;
            end
            if (!va.video_on) vid_lo++;
            if (!va.h_sync) begin
                hs_lo++;
                if (first_hs < 0) first_hs = int'(va.pix_x);
            end
            if (va.v_sync !== 1'b1) vs_bad++;
            if (va.line_start && ls1 < 0) ls1 = n;
        end
        check("first_tick", 32'(first_tick), 3);
        check("tick_cnt",   32'(ticks), 800);
        check("ls1_at",     32'(ls1), 3199);
        check("hs_lo_cnt",  32'(hs_lo), 384);
        check("hs_first_x", 32'(first_hs), 656);
        check("vid_lo_cnt", 32'(vid_lo), 640);
        check("vs_line0",   32'(vs_bad), 0);
        check("line1_x",    32'(va.pix_x), 0);
        check("line1_y",    32'(va.pix_y), 1);

        // Run to mid-line, then freeze for 10 clocks.
        for (int n = 3201; n <= 4000; n++) step();
        check("mid_x", 32'(va.pix_x), 200);
        check("mid_y", 32'(va.pix_y), 1);
        snap_x = int'(va.pix_x); snap_y = int'(va.pix_y);
        snap_hs = int'(va.h_sync); snap_vs = int'(va.v_sync);
        snap_vid = int'(va.video_on); snap_fc = int'(va.frame_count);
        en_a = 1'b0;
        #1;
        frozen_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (va.pix_tick || va.line_start || va.frame_start) frozen_bad++;
            step();
            if (int'(va.pix_x) != snap_x || int'(va.pix_y) != snap_y ||
                int'(va.h_sync) != snap_hs || int'(va.v_sync) != snap_vs ||
                int'(va.video_on) != snap_vid || int'(va.frame_count) != snap_fc)
                frozen_bad++;
            if (va.pix_tick || va.line_start || va.frame_start) frozen_bad++;
        end
        check("frozen", 32'(frozen_bad), 0);

        // Resume: next line_start lands after the same count of enabled clocks.
        en_a = 1'b1;
        ls2 = -1;
        for (int n = 4001; n <= 7300; n++) begin
            step();
            if (va.line_start) begin
                ls2 = n;
                break;
            end
        end
        check("ls2_at", 32'(ls2), 6399);

        // Reset mid-frame.
        rst_a = 1'b1;
        step();
        check("mrst_x",    32'(va.pix_x), 0);
        check("mrst_y",    32'(va.pix_y), 0);
        check("mrst_fc",   32'(va.frame_count), 0);
        check("mrst_vid",  32'(va.video_on), 0);
        check("mrst_tick", 32'(va.pix_tick), 0);
        rst_a = 1'b0;
        step();
        check("mrel_x",   32'(va.pix_x), 0);
        check("mrel_vid", 32'(va.video_on), 1);

        // Small configuration: 8 clocks per line, 48 per frame, active-high syncs.
        rst_b = 1'b0;
        vb_vs_hi = 0; vb_vid_hi = 0; fs_k = 0;
        for (int n = 1; n <= 290; n++) begin
            step();
            if (n <= 16) check($sformatf("b_x%0d", n), 32'(vb.pix_x), 32'(n % 8));
            if (n <= 8)
                check($sformatf("b_hs%0d", n), 32'(vb.h_sync),
                      ((n % 8) == 5 || (n % 8) == 6) ? 32'd1 : 32'd0);
            if (n <= 48) begin
                if (vb.v_sync)   vb_vs_hi++;
                if (vb.video_on) vb_vid_hi++;
            end
            if (vb.frame_start) begin
                check($sformatf("b_fs%0d_at", fs_k), 32'(n), 32'(47 + 48 * fs_k));
                check($sformatf("b_fs%0d_fc", fs_k), 32'(vb.frame_count), 32'(fs_k % 4));
                fs_k++;
            end
        end
        check("b_vs_hi", 32'(vb_vs_hi), 8);
        check("b_vid_hi", 32'(vb_vid_hi), 12);
        check("b_fs_cnt", 32'(fs_k), 6);

        // Reset coinciding with a frame_start: reset wins.
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (vb.frame_start) begin
                found = 1'b1;
                break;
            end
        end
        check("b_fs_wait", 32'(found), 1);
        check("b_fs6_fc", 32'(vb.frame_count), 2);
        rst_b = 1'b1;
        step();
        check("b_rst_fc", 32'(vb.frame_count), 0);
        check("b_rst_x",  32'(vb.pix_x), 0);
        check("b_rst_y",  32'(vb.pix_y), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
